sd_spi_block: RTL and testbench
===============================

Name: sd_spi_block

Overview:
SPI-mode SD card sector engine directly downstream of the sector cache controller. It executes one single-block read (CMD17) or write (CMD24) per start pulse. Data moves between the card and the 512-byte sector buffer RAM that the cache shares. It reports `busy` back to the cache. Card power-up initialisation is handled by a separate block; this block starts no transfer until `card_ready` is high.

Parameters:
- `CLK_DIV`, default 4: system clocks per SCLK half-period; minimum 1.
- `TIMEOUT`, default 65535: maximum byte polls while waiting for R1, the data token, or card-busy release.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset.
- `read_spi` in 1: one-cycle pulse; fetch `block` into the buffer.
- `write_spi` in 1: one-cycle pulse; flush the buffer to `block`.
- `block` in 23: sector number; sampled on the start-pulse cycle.
- `card_ready` in 1: initialisation complete.
- `busy` out 1: transfer in progress.
- `error` out 1: sticky failure flag; cleared by the next accepted start.
- `buf_addr` out 9: sector buffer byte address.
- `buf_wdata` out 8: byte written to the buffer.
- `buf_we` out 1: buffer write strobe.
- `buf_rdata` in 8: buffer read data, valid one cycle after `buf_addr`.
- `sd_cs_n` out 1: card chip select.
- `sd_sclk` out 1: SPI clock.
- `sd_mosi` out 1: SPI data to the card.
- `sd_miso` in 1: SPI data from the card.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - `busy`=0, `error`=0, `buf_we`=0, `buf_addr`=0, `buf_wdata`=0.
  - `sd_cs_n`=1, `sd_sclk`=0, `sd_mosi`=1.
  - FSM in IDLE.
- Reset mid-transfer aborts immediately with the same values; no trailing clocks are sent.
- Start acceptance:
  - A start is accepted only in IDLE with `card_ready`=1.
  - `busy` is registered and is high on the cycle after the pulse. This is required: the cache samples the cycle after its pulse.
  - Pulses arriving while busy, or while `card_ready`=0, are ignored.
  - If `read_spi` and `write_spi` are high together, write wins.
- SPI timing:
  - Mode 0: SCLK idles low. MOSI changes after the falling edge; MISO is sampled on the rising edge.
  - One byte takes 16*`CLK_DIV` clocks, MSB first.
  - Polling bytes send 0xFF.
- Command frame:
  - Bytes in order: 0x40|cmd, then 32-bit argument = {`block`,9'b0} (byte addressing), MSB first, then CRC 0xFF.
  - `sd_cs_n` is low from CMD through the end of the transfer.
- FSM states: IDLE, CMD, R1, TOKEN, RDATA, RCRC, WGAP, WTOKEN, WDATA, WCRC, DRESP, WBUSY, TAIL.
- Read path:
  - CMD (17) -> R1: poll until a byte has bit7=0; it must be 0x00, else error.
  - TOKEN: poll until 0xFE. Any other non-0xFF byte is an error.
  - RDATA: 512 bytes. Each received byte is written with `buf_we` pulsed for one cycle; `buf_addr` runs 0..511.
  - RCRC: two bytes, discarded.
  - Then TAIL.
- Write path:
  - CMD (24) -> R1, same rule as the read path.
  - WGAP: one 0xFF byte.
  - WTOKEN: send 0xFE.
  - WDATA: 512 bytes from the buffer. `buf_addr` is prefetched one cycle before each byte load.
  - WCRC: send 0xFF 0xFF.
  - DRESP: poll for the response; (byte & 0x1F) must equal 0x05, else error.
  - WBUSY: poll until a byte equals 0xFF.
  - Then TAIL.
- Timeouts: R1, TOKEN, DRESP and WBUSY each allow at most `TIMEOUT` polled bytes. On expiry, set `error` and go to TAIL.
- TAIL:
  - Raise `sd_cs_n`, then send 8 clocks of 0xFF with CS high.
  - Then IDLE; `busy` falls on the same edge.
  - Every path to IDLE, including error paths, passes through TAIL.
- Counters: byte index is 10 bits and wraps only at state exit (never used past 511); the clock divider counter is 16 bits.

Decomposition:
- Package `sd_pkg`:
  - FSM state enum.
  - CMD17/CMD24 opcodes, token 0xFE, data-response mask and value, sector size 512.
- One sub-module, `sd_spi_byte`: full-duplex byte shifter with the `CLK_DIV` divider.
  - Inputs: `start`, `tx[7:0]`.
  - Outputs: `done` pulse, `rx[7:0]`, `sclk`, `mosi`.
- The top-level FSM sequences bytes only.

Test Plan:
- Read, block=3, card model returns R1 0x00, two 0xFF polls, 0xFE, bytes i&0xFF, CRC -> MOSI carries 0x51 00 00 06 00 FF; buffer holds i&0xFF at address i for all 512; `error`=0; `busy` high the cycle after the pulse and low after 8 tail clocks.
- Write, block=1, buffer preloaded with 511-i, card responds 0xE5 then 3 busy bytes 0x00 then 0xFF -> card receives 0x58 00 00 02 00 FF, 0xFF, 0xFE, 512 bytes 511-i (low 8 bits), FF FF; `error`=0.
- R1=0x04 on CMD17 -> `error`=1, no `buf_we`, CS high, returns to IDLE; the next read with a good card clears `error`.
- Data response 0x0B on write -> `error`=1, no WBUSY polling, TAIL executed.
- Card never sends the token (`TIMEOUT`=16) -> `error`=1 after 16 polls.
- Simultaneous `read_spi`+`write_spi`; pulse while busy; pulse with `card_ready`=0; reset asserted at byte 200 of RDATA -> write executed; second pulse ignored; no start; outputs at reset values the cycle after `rst`.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD sector engine.
// Commands, tokens and sector geometry live here.
package sd_pkg;

   typedef enum logic [3:0] {
      IDLE, CMD, R1, TOKEN, RDATA, RCRC, WGAP,
      WTOKEN, WDATA, WCRC, DRESP, WBUSY, TAIL
   } state_t;

   localparam logic [5:0] CMD17        = 6'd17;
   localparam logic [5:0] CMD24        = 6'd24;
   localparam logic [7:0] START_TOKEN  = 8'hFE;
   localparam logic [7:0] IDLE_BYTE    = 8'hFF;
   localparam logic [7:0] DRESP_MASK   = 8'h1F;
   localparam logic [7:0] DRESP_OK     = 8'h05;
   localparam logic [9:0] SECTOR_BYTES = 10'd512;
   localparam logic [9:0] LAST_BYTE    = SECTOR_BYTES - 10'd1;

endpackage

// File: rtl/sd_spi_block_if.sv
// Cache-side handshake, sector buffer port and SD card pins.
// master = cache/card side, slave = sector engine.
interface sd_spi_block_if;

   logic        read_spi;
   logic        write_spi;
   logic [22:0] block;
   logic        card_ready;
   logic        busy;
   logic        error;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_wdata;
   logic        buf_we;
   logic [7:0]  buf_rdata;
   logic        sd_cs_n;
   logic        sd_sclk;
   logic        sd_mosi;
   logic        sd_miso;

   modport master (
      output read_spi, write_spi, block, card_ready,
      output buf_rdata, sd_miso,
      input  busy, error, buf_addr, buf_wdata, buf_we,
      input  sd_cs_n, sd_sclk, sd_mosi
   );

   modport slave (
      input  read_spi, write_spi, block, card_ready,
      input  buf_rdata, sd_miso,
      output busy, error, buf_addr, buf_wdata, buf_we,
      output sd_cs_n, sd_sclk, sd_mosi
   );

endinterface

// File: rtl/sd_spi_byte.sv
// Mode-0 full-duplex SPI byte shifter, MSB first.
// SCLK half-period is CLK_DIV system clocks.
module sd_spi_byte #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx,
   input  logic       miso,
   output logic       done,
   output logic [7:0] rx,
   output logic       sclk,
   output logic       mosi
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   logic        active;
   logic [15:0] div;
   logic [2:0]  bits;
   logic [7:0]  shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         div    <= '0;
         bits   <= '0;
         shift  <= '0;
         rx     <= '0;
         done   <= 1'b0;
         sclk   <= 1'b0;
         mosi   <= 1'b1;
      end else begin
         done <= 1'b0;
         if (!active) begin
            if (start) begin
               active <= 1'b1;
               div    <= '0;
               bits   <= '0;
               shift  <= tx;
               mosi   <= tx[7];
            end
         end else if (div != DIV_LAST) begin
            div <= div + 16'd1;
         end else begin
            div  <= '0;
            sclk <= ~sclk;
            if (!sclk) begin
               rx <= {rx[6:0], miso};
            end else if (bits == 3'd7) begin
               // last falling edge: byte complete, MOSI back to idle-high
               active <= 1'b0;
               done   <= 1'b1;
               mosi   <= 1'b1;
            end else begin
               bits  <= bits + 3'd1;
               shift <= {shift[6:0], 1'b0};
               mosi  <= shift[6];
            end
         end
      end
   end

endmodule

// File: rtl/sd_spi_block.sv
// SD card single-block read/write sequencer (CMD17/CMD24).
// Sequences whole bytes; bit timing lives in sd_spi_byte.
module sd_spi_block
   import sd_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int TIMEOUT = 65535
) (
   input logic           clk,
   input logic           rst,
   sd_spi_block_if.slave bus
);

   localparam logic [15:0] POLL_LAST = 16'(TIMEOUT - 1);

   state_t      state, nxt_state;
   logic [9:0]  cnt, nxt_cnt;
   logic [15:0] poll, nxt_poll;
   logic        wr, nxt_wr;
   logic [22:0] blk, nxt_blk;
   logic        err, nxt_err;
   logic        busy, nxt_busy;
   logic        cs_n, nxt_cs_n;
   logic        we, nxt_we;
   logic [8:0]  addr, nxt_addr;
   logic [7:0]  wdata, nxt_wdata;
   logic        go, bdone, fail, expired;
   logic [7:0]  go_tx, brx;
   logic [31:0] arg;

   sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
      .clk   (clk),
      .rst   (rst),
      .start (go),
      .tx    (go_tx),
      .miso  (bus.sd_miso),
      .done  (bdone),
      .rx    (brx),
      .sclk  (bus.sd_sclk),
      .mosi  (bus.sd_mosi)
   );

   assign expired       = (poll == POLL_LAST);
   assign bus.busy      = busy;
   assign bus.error     = err;
   assign bus.buf_addr  = addr;
   assign bus.buf_wdata = wdata;
   assign bus.buf_we    = we;
   assign bus.sd_cs_n   = cs_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         poll  <= '0;
         wr    <= 1'b0;
         blk   <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
         cs_n  <= 1'b1;
         we    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         poll  <= nxt_poll;
         wr    <= nxt_wr;
         blk   <= nxt_blk;
         err   <= nxt_err;
         busy  <= nxt_busy;
         cs_n  <= nxt_cs_n;
         we    <= nxt_we;
         addr  <= nxt_addr;
         wdata <= nxt_wdata;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_poll  = poll;
      nxt_wr    = wr;
      nxt_blk   = blk;
      nxt_err   = err;
      nxt_busy  = busy;
      nxt_cs_n  = cs_n;
      nxt_we    = 1'b0;
      nxt_addr  = addr;
      nxt_wdata = wdata;
      fail      = 1'b0;
      go        = 1'b0;
      go_tx     = IDLE_BYTE;
      unique case (state)
         IDLE: begin
            if (bus.card_ready && (bus.read_spi || bus.write_spi)) begin
               nxt_state = CMD;
               nxt_wr    = bus.write_spi;
               nxt_blk   = bus.block;
               nxt_err   = 1'b0;
               nxt_busy  = 1'b1;
               nxt_cs_n  = 1'b0;
               go        = 1'b1;
            end
         end
         CMD: if (bdone) begin
            go = 1'b1;
            if (cnt == 10'd5) nxt_state = R1;
            else nxt_cnt = cnt + 10'd1;
         end
         R1: if (bdone) begin
            go = 1'b1;
            if (!brx[7]) begin
               if (brx == 8'h00) nxt_state = wr ? WGAP : TOKEN;
               else fail = 1'b1;
            end else if (expired) fail = 1'b1;
            else nxt_poll = poll + 16'd1;
         end
         TOKEN: if (bdone) begin
            go = 1'b1;
            if (brx == START_TOKEN) nxt_state = RDATA;
            else if (brx != IDLE_BYTE || expired) fail = 1'b1;
            else nxt_poll = poll + 16'd1;
         end
         RDATA: if (bdone) begin
            go        = 1'b1;
            nxt_we    = 1'b1;
            nxt_wdata = brx;
            nxt_addr  = cnt[8:0];
            if (cnt == LAST_BYTE) nxt_state = RCRC;
            else nxt_cnt = cnt + 10'd1;
         end
         RCRC: if (bdone) begin
            go = 1'b1;
            if (cnt == 10'd1) nxt_state = TAIL;
            else nxt_cnt = cnt + 10'd1;
         end
         WGAP: if (bdone) begin
            go        = 1'b1;
            nxt_state = WTOKEN;
            nxt_addr  = '0;
         end
         WTOKEN: if (bdone) begin
            go        = 1'b1;
            nxt_state = WDATA;
            nxt_addr  = 9'd1;
         end
         // buf_addr runs one byte ahead so buf_rdata is ready at each load
         WDATA: if (bdone) begin
            go = 1'b1;
            if (cnt == LAST_BYTE) nxt_state = WCRC;
            else begin
               nxt_cnt  = cnt + 10'd1;
               nxt_addr = 9'(cnt + 10'd2);
            end
         end
         WCRC: if (bdone) begin
            go = 1'b1;
            if (cnt == 10'd1) nxt_state = DRESP;
            else nxt_cnt = cnt + 10'd1;
         end
         DRESP: if (bdone) begin
            go = 1'b1;
            if (brx == IDLE_BYTE) begin
               if (expired) fail = 1'b1;
               else nxt_poll = poll + 16'd1;
            end else if ((brx & DRESP_MASK) == DRESP_OK) nxt_state = WBUSY;
            else fail = 1'b1;
         end
         WBUSY: if (bdone) begin
            go = 1'b1;
            if (brx == IDLE_BYTE) nxt_state = TAIL;
            else if (expired) fail = 1'b1;
            else nxt_poll = poll + 16'd1;
         end
         TAIL: if (bdone) begin
            nxt_state = IDLE;
            nxt_busy  = 1'b0;
         end
         default: nxt_state = IDLE;
      endcase
      if (fail) begin
         nxt_err   = 1'b1;
         nxt_state = TAIL;
      end
      if (nxt_state != state) begin
         nxt_cnt  = '0;
         nxt_poll = '0;
      end
      if (nxt_state == TAIL) nxt_cs_n = 1'b1;
      arg = {nxt_blk, 9'd0};
      case (nxt_state)
         CMD: begin
            case (nxt_cnt)
               10'd0:   go_tx = {2'b01, nxt_wr ? CMD24 : CMD17};
               10'd1:   go_tx = arg[31:24];
               10'd2:   go_tx = arg[23:16];
               10'd3:   go_tx = arg[15:8];
               10'd4:   go_tx = arg[7:0];
               default: go_tx = IDLE_BYTE;
            endcase
         end
         WTOKEN:  go_tx = START_TOKEN;
         WDATA:   go_tx = bus.buf_rdata;
         default: go_tx = IDLE_BYTE;
      endcase
   end

endmodule

// File: tb/tb_sd_spi_block.sv
// Scoreboard bench for sd_spi_block with a scripted SPI card model.
// CLK_DIV=1 and TIMEOUT=16 keep transfers short.
module tb_sd_spi_block;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sd_spi_block_if bus();

   sd_spi_block #(.CLK_DIV(1), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   logic [7:0]  mem [512];
   logic [7:0]  card_q [$];
   logic [7:0]  exp_mosi [$];
   logic [16:0] exp_buf [$];

   int rx_cnt   = 0;
   int tail_clk = 0;
   int we_cnt   = 0;
   int we0      = 0;
   int bitn     = 0;
   logic [7:0] rx_sh   = 8'h00;
   logic [7:0] cur_out = 8'hFF;
   logic prev_sclk = 1'b0;
   logic prev_cs   = 1'b1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %0h want %0h", tag, got, want);
   endtask

   always @(posedge clk) begin
      bus.buf_rdata <= mem[bus.buf_addr];
      if (bus.buf_we) mem[bus.buf_addr] = bus.buf_wdata;
   end

   always @(negedge clk) begin
      logic [16:0] e;
      if (!rst && bus.buf_we) begin
         we_cnt++;
         if (exp_buf.size() != 0) begin
            e = exp_buf.pop_front();
            check("buf_addr", {23'd0, bus.buf_addr}, {23'd0, e[16:8]});
            check("buf_data", {24'd0, bus.buf_wdata}, {24'd0, e[7:0]});
         end
      end
   end

   // card: mosi sampled on SCLK rise, miso updated after SCLK fall
   always @(negedge clk) begin
      if (rst) begin
         bitn = 0;
         cur_out = 8'hFF;
         bus.sd_miso = 1'b1;
      end else if (prev_cs && !bus.sd_cs_n) begin
         rx_cnt = 0;
         tail_clk = 0;
         bitn = 0;
         cur_out = 8'hFF;
         bus.sd_miso = 1'b1;
      end else if (!prev_sclk && bus.sd_sclk) begin
         if (bus.sd_cs_n) tail_clk++;
         else begin
            rx_sh = {rx_sh[6:0], bus.sd_mosi};
            bitn++;
            if (bitn == 8) begin
               bitn = 0;
               rx_cnt++;
               if (exp_mosi.size() != 0)
                  check("mosi_byte", {24'd0, rx_sh}, {24'd0, exp_mosi.pop_front()});
               if (rx_cnt >= 6 && card_q.size() != 0) cur_out = card_q.pop_front();
               else cur_out = 8'hFF;
            end
         end
      end else if (prev_sclk && !bus.sd_sclk && !bus.sd_cs_n) begin
         bus.sd_miso = cur_out[7 - bitn];
      end
      prev_sclk = bus.sd_sclk;
      prev_cs = bus.sd_cs_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic rd, input logic wrt, input logic [22:0] blk);
      bus.read_spi = rd;
      bus.write_spi = wrt;
      bus.block = blk;
      tick();
      bus.read_spi = 1'b0;
      bus.write_spi = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 20000) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_err"}, {31'd0, bus.error}, 32'd0);
      check({tag, "_cs"}, {31'd0, bus.sd_cs_n}, 32'd1);
      check({tag, "_sclk"}, {31'd0, bus.sd_sclk}, 32'd0);
      check({tag, "_mosi"}, {31'd0, bus.sd_mosi}, 32'd1);
      check({tag, "_we"}, {31'd0, bus.buf_we}, 32'd0);
      check({tag, "_addr"}, {23'd0, bus.buf_addr}, 32'd0);
      check({tag, "_wdata"}, {24'd0, bus.buf_wdata}, 32'd0);
   endtask

   task automatic push_cmd(input logic [7:0] op, input logic [22:0] blk);
      logic [31:0] a;
      a = {blk, 9'd0};
      exp_mosi.push_back(8'h40 | op);
      exp_mosi.push_back(a[31:24]);
      exp_mosi.push_back(a[23:16]);
      exp_mosi.push_back(a[15:8]);
      exp_mosi.push_back(a[7:0]);
      exp_mosi.push_back(8'hFF);
   endtask

   task automatic push_write(input logic [22:0] blk);
      for (int i = 0; i < 512; i++) mem[i] = 8'(511 - i);
      push_cmd(8'd24, blk);
      exp_mosi.push_back(8'hFF);
      exp_mosi.push_back(8'hFF);
      exp_mosi.push_back(8'hFE);
      for (int i = 0; i < 512; i++) exp_mosi.push_back(8'(511 - i));
      exp_mosi.push_back(8'hFF);
      exp_mosi.push_back(8'hFF);
      card_q.push_back(8'h00);
      for (int i = 0; i < 516; i++) card_q.push_back(8'hFF);
   endtask

   task automatic push_read(input logic [22:0] blk, input int mul);
      logic [7:0] d;
      push_cmd(8'd17, blk);
      card_q.push_back(8'h00);
      card_q.push_back(8'hFF);
      card_q.push_back(8'hFF);
      card_q.push_back(8'hFE);
      for (int i = 0; i < 512; i++) begin
         d = 8'(i * mul + mul - 1);
         card_q.push_back(d);
         exp_buf.push_back({9'(i), d});
      end
      card_q.push_back(8'hA5);
      card_q.push_back(8'h5A);
   endtask

   task automatic do_read(input string tag, input logic [22:0] blk, input int mul);
      we0 = we_cnt;
      push_read(blk, mul);
      start(1'b1, 1'b0, blk);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      check({tag, "_errclr"}, {31'd0, bus.error}, 32'd0);
      wait_idle(tag);
      check({tag, "_err"}, {31'd0, bus.error}, 32'd0);
      check({tag, "_we"}, we_cnt - we0, 32'd512);
      check({tag, "_tail"}, tail_clk, 32'd8);
      check({tag, "_sb"}, exp_buf.size() + exp_mosi.size(), 32'd0);
   endtask

   initial begin
      logic act;
      int n;
      bus.read_spi = 1'b0;
      bus.write_spi = 1'b0;
      bus.block = '0;
      bus.card_ready = 1'b1;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      repeat (3) tick();
      check_rst("reset");
      rst = 1'b0;
      tick();

      bus.card_ready = 1'b0;
      start(1'b1, 1'b0, 23'd3);
      check("notready_busy", {31'd0, bus.busy}, 32'd0);
      check("notready_cs", {31'd0, bus.sd_cs_n}, 32'd1);
      bus.card_ready = 1'b1;
      repeat (3) tick();
      check("notready_late", {31'd0, bus.busy}, 32'd0);

      do_read("rd3", 23'd3, 1);

      we0 = we_cnt;
      push_write(23'd1);
      card_q.push_back(8'hE5);
      repeat (3) card_q.push_back(8'h00);
      card_q.push_back(8'hFF);
      start(1'b0, 1'b1, 23'd1);
      check("wr_busy", {31'd0, bus.busy}, 32'd1);
      wait_idle("wr");
      check("wr_err", {31'd0, bus.error}, 32'd0);
      check("wr_bytes", rx_cnt, 32'd528);
      check("wr_we", we_cnt - we0, 32'd0);
      check("wr_tail", tail_clk, 32'd8);
      check("wr_sb", exp_mosi.size(), 32'd0);

      we0 = we_cnt;
      push_cmd(8'd17, 23'd5);
      card_q.push_back(8'h04);
      start(1'b1, 1'b0, 23'd5);
      wait_idle("r1e");
      check("r1e_err", {31'd0, bus.error}, 32'd1);
      check("r1e_we", we_cnt - we0, 32'd0);
      check("r1e_cs", {31'd0, bus.sd_cs_n}, 32'd1);
      check("r1e_bytes", rx_cnt, 32'd7);
      check("r1e_tail", tail_clk, 32'd8);
      do_read("rd0", 23'd0, 5);

      push_write(23'd2);
      card_q.push_back(8'h0B);
      card_q.push_back(8'h00);
      start(1'b0, 1'b1, 23'd2);
      wait_idle("dre");
      check("dre_err", {31'd0, bus.error}, 32'd1);
      check("dre_bytes", rx_cnt, 32'd524);
      check("dre_tail", tail_clk, 32'd8);
      card_q.delete();

      we0 = we_cnt;
      push_cmd(8'd17, 23'd2);
      card_q.push_back(8'h00);
      start(1'b1, 1'b0, 23'd2);
      wait_idle("tmo");
      check("tmo_err", {31'd0, bus.error}, 32'd1);
      check("tmo_bytes", rx_cnt, 32'd23);
      check("tmo_we", we_cnt - we0, 32'd0);
      check("tmo_tail", tail_clk, 32'd8);

      push_write(23'd4);
      card_q.push_back(8'hE5);
      card_q.push_back(8'h00);
      card_q.push_back(8'hFF);
      start(1'b1, 1'b1, 23'd4);
      check("both_busy", {31'd0, bus.busy}, 32'd1);
      repeat (50) tick();
      start(1'b1, 1'b0, 23'd9);
      wait_idle("both");
      check("both_err", {31'd0, bus.error}, 32'd0);
      check("both_bytes", rx_cnt, 32'd526);
      check("both_sb", exp_mosi.size(), 32'd0);
      repeat (5) tick();
      check("both_ignored", {31'd0, bus.busy}, 32'd0);

      we0 = we_cnt;
      push_read(23'd7, 3);
      start(1'b1, 1'b0, 23'd7);
      n = 0;
      while ((we_cnt - we0) < 200 && n < 20000) begin
         tick();
         n++;
      end
      check("abort_at200", we_cnt - we0, 32'd200);
      rst = 1'b1;
      tick();
      check_rst("abort");
      rst = 1'b0;
      exp_buf.delete();
      card_q.delete();
      exp_mosi.delete();
      act = 1'b0;
      repeat (40) begin
         tick();
         if (bus.sd_sclk || !bus.sd_cs_n || bus.busy) act = 1'b1;
      end
      check("abort_quiet", {31'd0, act}, 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
